// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: W pipeline register outputs presented to the write-back stage
interface writeback_regfile_if;
  logic [2:0]  W_stat;
  logic [63:0] W_pc;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  modport master (output W_stat, W_pc, W_icode, W_valE, W_valM, W_dstE, W_dstM);
  modport slave  (input  W_stat, W_pc, W_icode, W_valE, W_valM, W_dstE, W_dstM);
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 write-back stage holding the register file, status latch,
// last committed PC and retired-instruction counter.
module writeback_regfile #(
  parameter int NREG  = 15,
  parameter int CNT_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  writeback_regfile_if.slave   w,
  input  logic [3:0]           d_srcA_i,
  input  logic [3:0]           d_srcB_i,
  output logic [63:0]          d_rvalA_o,
  output logic [63:0]          d_rvalB_o,
  output logic [2:0]           stat_o,
  output logic                 halted_o,
  output logic [63:0]          last_pc_o,
  output logic [CNT_W-1:0]     retired_cnt_o
);
  localparam logic [3:0] INOP = 4'h1;
  localparam logic [3:0] NR   = 4'(NREG);
  logic [63:0]      r_regs [NREG];
  logic [2:0]       r_stat;
  logic             r_halted;
  logic [63:0]      r_last_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_commit;
  logic             w_fault;
  logic             w_we_e;
  logic             w_we_m;
  assign w_commit = ~r_halted & (w.W_stat == 3'd1);
  assign w_fault  = ~r_halted & (w.W_stat >= 3'd2);
  assign w_we_e   = w_commit & (w.W_dstE < NR);
  assign w_we_m   = w_commit & (w.W_dstM < NR);
  // no write-to-read bypass; decode forwards W values itself
  assign d_rvalA_o     = (d_srcA_i < NR) ? r_regs[d_srcA_i] : '0;
  assign d_rvalB_o     = (d_srcB_i < NR) ? r_regs[d_srcB_i] : '0;
  assign stat_o        = r_stat;
  assign halted_o      = r_halted;
  assign last_pc_o     = r_last_pc;
  assign retired_cnt_o = r_cnt;
  // valM is written last so it wins when both destinations match (popq %rsp)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_regs <= '{default: '0};
    end else begin
      if (w_we_e) r_regs[w.W_dstE] <= w.W_valE;
      if (w_we_m) r_regs[w.W_dstM] <= w.W_valM;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat    <= 3'd1;
      r_halted  <= 1'b0;
      r_last_pc <= '0;
      r_cnt     <= '0;
    end else if (w_commit) begin
      r_last_pc <= w.W_pc;
      if (w.W_icode != INOP) r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_fault) begin
      r_halted  <= 1'b1;
      r_stat    <= (w.W_stat > 3'd4) ? 3'd4 : w.W_stat;
      r_last_pc <= w.W_pc;
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed and randomized checks of writeback_regfile
// against an array-based architectural model.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  writeback_regfile_if wif ();
  logic [3:0]  src_a, src_b;
  logic [63:0] rval_a, rval_b, last_pc, cnt;
  logic [2:0]  stat;
  logic        halted;
  writeback_regfile dut (
    .clk_i(clk), .rst_n_i(rst_n), .w(wif.slave),
    .d_srcA_i(src_a), .d_srcB_i(src_b), .d_rvalA_o(rval_a), .d_rvalB_o(rval_b),
    .stat_o(stat), .halted_o(halted), .last_pc_o(last_pc), .retired_cnt_o(cnt)
  );
  logic [63:0] m_reg [15];
  logic        m_halted;
  logic [2:0]  m_stat;
  logic [63:0] m_pc, m_cnt;
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] m_read(input logic [3:0] a);
    return (a == 4'hF) ? 64'h0 : m_reg[a];
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = '0;
    m_halted = 1'b0;
    m_stat   = 3'd1;
    m_pc     = '0;
    m_cnt    = '0;
  endtask
  task automatic m_edge();
    if (m_halted) return;
    if (wif.W_stat == 3'd1) begin
      if (wif.W_dstE != 4'hF) m_reg[wif.W_dstE] = wif.W_valE;
      if (wif.W_dstM != 4'hF) m_reg[wif.W_dstM] = wif.W_valM;
      m_pc = wif.W_pc;
      if (wif.W_icode != 4'h1) m_cnt = m_cnt + 1;
    end else if (wif.W_stat != 3'd0) begin
      m_halted = 1'b1;
      m_stat   = (wif.W_stat > 3'd4) ? 3'd4 : wif.W_stat;
      m_pc     = wif.W_pc;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ":stat"},   64'(stat),   64'(m_stat));
    chk({tag, ":halted"}, 64'(halted), 64'(m_halted));
    chk({tag, ":pc"},     last_pc,     m_pc);
    chk({tag, ":cnt"},    cnt,         m_cnt);
    chk({tag, ":rA"},     rval_a,      m_read(src_a));
    chk({tag, ":rB"},     rval_b,      m_read(src_b));
  endtask
  task automatic drive(input logic [2:0] s, input logic [63:0] pc, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    wif.W_stat = s; wif.W_pc = pc; wif.W_icode = ic;
    wif.W_valE = ve; wif.W_valM = vm; wif.W_dstE = de; wif.W_dstM = dm;
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    m_reset();
    drive(3'd0, 64'h0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    src_a = 4'd0;
    src_b = 4'hF;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    drive(3'd1, 64'h10, 4'h3, 64'h1234, 64'h0, 4'd2, 4'hF);
    src_a = 4'd2;
    step("t1");
    chk("t1_val", rval_a, 64'h1234);
    chk("t1_cnt", cnt, 64'd1);
    chk("t1_pc", last_pc, 64'h10);
    drive(3'd1, 64'h1A, 4'hB, 64'h100, 64'h200, 4'd4, 4'd4);
    src_a = 4'd4;
    step("t2");
    chk("t2_valM_wins", rval_a, 64'h200);
    chk("t2_cnt", cnt, 64'd2);
    drive(3'd0, 64'h99, 4'h1, 64'hDEAD, 64'hDEAD, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) step("bubble");
    chk("bubble_cnt", cnt, 64'd2);
    chk("bubble_pc", last_pc, 64'h1A);
    chk("bubble_stat", 64'(stat), 64'd1);
    drive(3'd1, 64'h20, 4'h3, 64'hBEEF, 64'h0, 4'd2, 4'hF);
    src_a = 4'd2;
    #1 chk("same_cycle_old", rval_a, 64'h1234);
    step("t3");
    chk("next_cycle_new", rval_a, 64'hBEEF);
    chk("srcB_none", rval_b, 64'h0);
    drive(3'd3, 64'h40, 4'h6, 64'h5, 64'h0, 4'd1, 4'hF);
    src_a = 4'd1;
    step("fault");
    chk("fault_halted", 64'(halted), 64'd1);
    chk("fault_stat", 64'(stat), 64'd3);
    chk("fault_pc", last_pc, 64'h40);
    chk("fault_nowrite", rval_a, 64'h0);
    drive(3'd1, 64'h48, 4'h3, 64'h7, 64'h0, 4'd1, 4'hF);
    step("post_halt");
    chk("post_halt_stat", 64'(stat), 64'd3);
    chk("post_halt_nowrite", rval_a, 64'h0);
    chk("post_halt_cnt", cnt, 64'd3);
    do_reset("async_rst");
    chk("async_rst_halted", 64'(halted), 64'd0);
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [2:0] s;
      r = int'($urandom_range(0, 99));
      s = (r < 75) ? 3'd1 : (r < 97) ? 3'd0 : 3'($urandom_range(2, 7));
      drive(s, {$urandom, $urandom}, 4'($urandom_range(0, 15)), {$urandom, $urandom},
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      src_a = 4'($urandom_range(0, 15));
      src_b = 4'($urandom_range(0, 15));
      step("rand");
      if (m_halted && $urandom_range(0, 7) == 0) do_reset("rand_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
